// File: rtl/dm_m.sv
// M-stage data memory: word-organised, little-endian, combinational read, store commit on clk.
// Optional DM_TRACE_EN prints one trace line per committed store.
module dm_m #(
  parameter int unsigned DEPTH  = 1024,
  parameter int unsigned ADDR_W = 10
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] instr_M,
  input  logic [31:0] data_alu_M,
  input  logic [31:0] wdata_M,
  input  logic [31:0] pcout_M,
  output logic [31:0] data_dm_M,
  output logic        align_err_M,
  output logic [31:0] wr_count_M
);

  typedef enum logic [5:0] {
    OP_SB = 6'b101000,
    OP_SH = 6'b101001,
    OP_SW = 6'b101011
  } store_op_e;

  logic [31:0]       mem [DEPTH];
  logic [ADDR_W-1:0] idx;
  logic [5:0]        opcode;
  logic              is_sw, is_sh, is_sb;
  logic              we;
  logic [3:0]        be;
  logic [31:0]       wdata_rep;
  logic [31:0]       merged_word;
  logic              unused_ok;

  assign opcode = instr_M[31:26];
  assign idx    = data_alu_M[ADDR_W+1:2];
  assign is_sw  = (opcode == OP_SW);
  assign is_sh  = (opcode == OP_SH);
  assign is_sb  = (opcode == OP_SB);

  assign align_err_M = (is_sw & (data_alu_M[1:0] != 2'b00)) | (is_sh & data_alu_M[0]);
  assign we          = (is_sw | is_sh | is_sb) & ~align_err_M;
  assign data_dm_M   = mem[idx];

  // Store data is replicated across lanes so byte enables alone pick the target bytes.
  always_comb begin
    be          = '0;
    wdata_rep   = wdata_M;
    merged_word = mem[idx];
    if (is_sw) begin
      be = '1;
    end else if (is_sh) begin
      be        = data_alu_M[1] ? 4'b1100 : 4'b0011;
      wdata_rep = {2{wdata_M[15:0]}};
    end else if (is_sb) begin
      be        = 4'b0001 << data_alu_M[1:0];
      wdata_rep = {4{wdata_M[7:0]}};
    end
    for (int unsigned k = 0; k < 4; k++) begin
      if (be[k]) merged_word[8*k +: 8] = wdata_rep[8*k +: 8];
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int unsigned i = 0; i < DEPTH; i++) mem[i] <= '0;
      wr_count_M <= '0;
    end else if (we) begin
      mem[idx]   <= merged_word;
      wr_count_M <= wr_count_M + 32'd1;
    end
  end

`ifdef DM_TRACE_EN
  always_ff @(posedge clk) begin
    if (reset && we)
      $display("%d@%h: *%h <= %h", $time, pcout_M, {data_alu_M[31:2], 2'b00}, merged_word);
  end
`endif

  assign unused_ok = ^{pcout_M, data_alu_M[31:ADDR_W+2], instr_M[25:0]};

endmodule

// File: tb/tb_dm_m.sv
// Directed, table-driven bench for dm_m: store merging, misalignment, aliasing and async reset.
module tb_dm_m;

  localparam logic [5:0] SW = 6'b101011;
  localparam logic [5:0] SH = 6'b101001;
  localparam logic [5:0] SB = 6'b101000;
  localparam logic [5:0] LW = 6'b100011;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] instr_M, data_alu_M, wdata_M, pcout_M;
  logic [31:0] data_dm_M;
  logic        align_err_M;
  logic [31:0] wr_count_M;

  int checks   = 0;
  int failures = 0;

  dm_m #(.DEPTH(1024), .ADDR_W(10)) dut (
    .clk        (clk),
    .reset      (reset),
    .instr_M    (instr_M),
    .data_alu_M (data_alu_M),
    .wdata_M    (wdata_M),
    .pcout_M    (pcout_M),
    .data_dm_M  (data_dm_M),
    .align_err_M(align_err_M),
    .wr_count_M (wr_count_M)
  );

  always #5 clk = ~clk;

  typedef struct {
    string       name;
    logic [31:0] instr;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic        exp_err;
    logic [31:0] exp_pre;
    logic [31:0] chk_addr;
    logic [31:0] exp_word;
    logic [31:0] exp_cnt;
  } vec_t;

  function automatic logic [31:0] ins(input logic [5:0] op);
    return {op, 5'd3, 5'd9, 16'h0040};
  endfunction

  function automatic vec_t mkv(input string n, input logic [31:0] i, input logic [31:0] a,
                               input logic [31:0] w, input logic e, input logic [31:0] pre,
                               input logic [31:0] ca, input logic [31:0] wd, input logic [31:0] c);
    vec_t v;
    v.name = n; v.instr = i; v.addr = a; v.wdata = w; v.exp_err = e;
    v.exp_pre = pre; v.chk_addr = ca; v.exp_word = wd; v.exp_cnt = c;
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  vec_t vecs[13];

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures + 1);
    $fatal(1);
  end

  initial begin
    vecs[0]  = mkv("sw_10",        ins(SW), 32'h10,   32'h12345678, 1'b0, 32'h0,        32'h10,  32'h12345678, 32'd1);
    vecs[1]  = mkv("sb_11",        ins(SB), 32'h11,   32'h000000AB, 1'b0, 32'h12345678, 32'h10,  32'h1234AB78, 32'd2);
    vecs[2]  = mkv("sh_12",        ins(SH), 32'h12,   32'h0000BEEF, 1'b0, 32'h1234AB78, 32'h10,  32'hBEEFAB78, 32'd3);
    vecs[3]  = mkv("sh_13_misal",  ins(SH), 32'h13,   32'h00001111, 1'b1, 32'hBEEFAB78, 32'h10,  32'hBEEFAB78, 32'd3);
    vecs[4]  = mkv("sw_12_misal",  ins(SW), 32'h12,   32'h22222222, 1'b1, 32'hBEEFAB78, 32'h10,  32'hBEEFAB78, 32'd3);
    vecs[5]  = mkv("lw_nowrite",   ins(LW), 32'h10,   32'hFFFFFFFF, 1'b0, 32'hBEEFAB78, 32'h10,  32'hBEEFAB78, 32'd3);
    vecs[6]  = mkv("sb_13",        ins(SB), 32'h13,   32'h00000011, 1'b0, 32'hBEEFAB78, 32'h10,  32'h11EFAB78, 32'd4);
    vecs[7]  = mkv("sb_10_lowbyte",ins(SB), 32'h10,   32'hFFFFFF22, 1'b0, 32'h11EFAB78, 32'h10,  32'h11EFAB22, 32'd5);
    vecs[8]  = mkv("sh_10_lowhalf",ins(SH), 32'h10,   32'h12343333, 1'b0, 32'h11EFAB22, 32'h10,  32'h11EF3333, 32'd6);
    vecs[9]  = mkv("sw_alias",     ins(SW), 32'h1010, 32'hCAFEF00D, 1'b0, 32'h11EF3333, 32'h10,  32'hCAFEF00D, 32'd7);
    vecs[10] = mkv("sw_top_word",  ins(SW), 32'hFFC,  32'hDEADBEEF, 1'b0, 32'h0,        32'hFFC, 32'hDEADBEEF, 32'd8);
    vecs[11] = mkv("op0_nowrite",  32'h0000FFFF, 32'h14, 32'h0BADF00D, 1'b0, 32'h0,     32'h14,  32'h0,        32'd8);
    vecs[12] = mkv("word0_intact", ins(LW), 32'h0,    32'h0,        1'b0, 32'h0,        32'h0,   32'h0,        32'd8);

    // Reset phase: outputs clear with no clock, align_err stays combinational.
    reset = 1'b0; instr_M = '0; data_alu_M = '0; wdata_M = '0; pcout_M = 32'h00400000;
    #12;
    chk("rst_data",  data_dm_M, 32'h0);
    chk("rst_count", wr_count_M, 32'h0);
    chk("rst_err",   {31'h0, align_err_M}, 32'h0);
    data_alu_M = 32'hFFC; #1;
    chk("rst_top_word", data_dm_M, 32'h0);
    instr_M = ins(SH); data_alu_M = 32'h13; #1;
    chk("rst_err_comb", {31'h0, align_err_M}, 32'h1);
    instr_M = '0; data_alu_M = '0;
    @(negedge clk); reset = 1'b1;

    for (int i = 0; i < 13; i++) begin
      @(negedge clk);
      instr_M = vecs[i].instr; data_alu_M = vecs[i].addr; wdata_M = vecs[i].wdata;
      pcout_M = 32'h00400000 + 32'(4 * i);
      #1;
      chk({vecs[i].name, "_err"}, {31'h0, align_err_M}, {31'h0, vecs[i].exp_err});
      chk({vecs[i].name, "_pre"}, data_dm_M, vecs[i].exp_pre);
      @(posedge clk); #1;
      instr_M = '0; data_alu_M = vecs[i].chk_addr; #1;
      chk({vecs[i].name, "_word"}, data_dm_M, vecs[i].exp_word);
      chk({vecs[i].name, "_cnt"}, wr_count_M, vecs[i].exp_cnt);
    end

    // Reset mid-cycle with a store pending: reset wins, nothing commits while held.
    @(negedge clk);
    instr_M = ins(SW); data_alu_M = 32'h1010; wdata_M = 32'h55AA55AA; #1;
    chk("mid_pre", data_dm_M, 32'hCAFEF00D);
    #2 reset = 1'b0; #1;
    chk("mid_rst_word", data_dm_M, 32'h0);
    chk("mid_rst_cnt",  wr_count_M, 32'h0);
    @(posedge clk); #1;
    chk("held_rst_word", data_dm_M, 32'h0);
    chk("held_rst_cnt",  wr_count_M, 32'h0);
    @(negedge clk); reset = 1'b1; #1;
    chk("release_word", data_dm_M, 32'h0);
    @(posedge clk); #1;
    chk("first_commit_word", data_dm_M, 32'h55AA55AA);
    chk("first_commit_cnt",  wr_count_M, 32'h1);
    instr_M = '0;
    data_alu_M = 32'hFFC; #1;
    chk("post_rst_top", data_dm_M, 32'h0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
